// File: rtl/inst_prefetch_if.sv
// Instruction memory port between the prefetcher (master) and instruction memory (slave).
// Requests are accepted on mem_gnt; read data returns in request order on mem_rvalid.
interface inst_prefetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: runs ahead of the core into a small in-order FIFO
// and restarts the stream at the core's address on any redirect.
module inst_prefetch #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     boot_addr,
    input  logic [31:0]     core_addr,
    input  logic            flush,
    output logic [31:0]     instruction,
    output logic            inst_ready,
    inst_prefetch_if.master mem
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = AW + 1;
    localparam int          OW        = $clog2(MAX_OUT) + 1;
    localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
    localparam logic [31:0] MAX_OUT_U = 32'(MAX_OUT);
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic {S_FETCH, S_DRAIN} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_fetch_addr, r_stream_base, r_hold_addr;
    logic        r_hold, r_hold_stale;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [OW-1:0] r_outstanding, r_drop_cnt;
    logic [31:0] r_fifo [DEPTH];

    logic [31:0] w_core_word;
    logic        w_redirect, w_can_issue, w_issue;
    logic        w_gnt, w_gnt_live, w_gnt_dead, w_rv_drop, w_rv_live, w_push, w_pop;
    logic [OW-1:0] w_out_next, w_drop_next;

    always_comb begin
        w_core_word = {core_addr[31:2], 2'b00};
        w_redirect  = flush
                   || ((r_count != '0 || r_outstanding != '0) && core_addr != r_stream_base)
                   || (r_count == '0 && r_outstanding == '0 && core_addr != r_fetch_addr);
        w_can_issue = (32'(r_count) + 32'(r_outstanding) < DEPTH_U)
                   && (32'(r_outstanding) + 32'(r_drop_cnt) < MAX_OUT_U);
    end

    // FSM outputs. mem_req is masked by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_issue = 1'b0;
        if (r_state == S_FETCH)
            w_issue = w_can_issue && !w_redirect;
        mem.mem_req  = rst_n && (r_hold || w_issue);
        mem.mem_addr = r_hold ? r_hold_addr : r_fetch_addr;
        inst_ready   = (r_count != '0) && (core_addr == r_stream_base) && !flush;
        instruction  = inst_ready ? r_fifo[r_rd_ptr] : NOP;
    end

    // A grant belongs to the dead stream if it lands in the redirect cycle or
    // completes a request that was held across an earlier redirect.
    always_comb begin
        w_gnt       = mem.mem_req && mem.mem_gnt;
        w_gnt_dead  = w_gnt && (w_redirect || r_hold_stale);
        w_gnt_live  = w_gnt && !w_gnt_dead;
        w_rv_drop   = mem.mem_rvalid && (r_drop_cnt != '0);
        w_rv_live   = mem.mem_rvalid && (r_drop_cnt == '0);
        w_push      = w_rv_live && !w_redirect;
        w_pop       = inst_ready;
        w_drop_next = r_drop_cnt - OW'(w_rv_drop) + OW'(w_gnt_dead)
                    + (w_redirect ? (r_outstanding - OW'(w_rv_live)) : '0);
        w_out_next  = w_redirect ? '0 : (r_outstanding + OW'(w_gnt_live) - OW'(w_rv_live));
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: if (w_drop_next != '0) w_state_next = S_DRAIN;
            S_DRAIN: if (w_drop_next == '0) w_state_next = S_FETCH;
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_FETCH;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_addr  <= boot_addr;
            r_stream_base <= boot_addr;
            r_hold_addr   <= '0;
            r_hold        <= 1'b0;
            r_hold_stale  <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            r_hold        <= mem.mem_req && !mem.mem_gnt;
            r_hold_stale  <= mem.mem_req && !mem.mem_gnt && (r_hold_stale || w_redirect);
            if (mem.mem_req && !mem.mem_gnt)
                r_hold_addr <= mem.mem_addr;
            if (w_redirect) begin
                r_fetch_addr  <= w_core_word;
                r_stream_base <= w_core_word;
                r_count       <= '0;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
            end else begin
                if (w_gnt_live)
                    r_fetch_addr <= r_fetch_addr + 32'd4;
                if (w_pop) begin
                    r_stream_base <= r_stream_base + 32'd4;
                    r_rd_ptr      <= r_rd_ptr + AW'(1);
                end
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= mem.mem_rdata;
    end

endmodule
